booth_r4_mult: RTL and testbench

BOOTH_R4_MULT -- requirements
Module: booth_r4_mult

---
 rtl/booth_pkg.sv | 20 ++
 rtl/booth_r4_enc.sv | 21 ++
 rtl/booth_r4_mult.sv | 141 ++++++++++++++
 tb/tb_booth_r4_mult.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// Shared encodings for the radix-4 Booth multiplier: control states and
// the per-digit accumulator operation selected by the digit encoder.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_e;

    typedef enum logic [2:0] {
        ZERO   = 3'd0,
        ADD_M  = 3'd1,
        ADD_2M = 3'd2,
        SUB_M  = 3'd3,
        SUB_2M = 3'd4
    } digit_op_e;

endpackage

// File: rtl/booth_r4_enc.sv
// Radix-4 Booth recoder: maps the overlapping multiplier triple
// {q1, q0, q-1} onto the accumulator operation for one digit.
module booth_r4_enc
    import booth_pkg::*;
(
    input  logic [2:0] triple,
    output digit_op_e  op_c
);

    always_comb begin
        op_c = ZERO;
        case (triple)
            3'b001, 3'b010: op_c = ADD_M;
            3'b011:         op_c = ADD_2M;
            3'b100:         op_c = SUB_2M;
            3'b101, 3'b110: op_c = SUB_M;
            default:        op_c = ZERO;
        endcase
    end

endmodule

// File: rtl/booth_r4_mult.sv
// Sequential radix-4 Booth multiplier: one digit retired per RUN cycle,
// fixed latency, signed or unsigned operands selected per operation.
module booth_r4_mult
    import booth_pkg::*;
#(
    parameter int unsigned WIDTH = 16
)
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int unsigned NDIG = WIDTH / 2 + 1;
    localparam int unsigned XW   = WIDTH + 2;
    localparam int unsigned AW   = WIDTH + 3;
    localparam int unsigned CW   = $clog2(NDIG + 1);

    state_e          state;
    state_e          state_next;
    digit_op_e       op_c;

    logic [XW-1:0]   m_q;
    logic [XW-1:0]   q_q;
    logic            qm1_q;
    logic [AW-1:0]   a_q;
    logic [CW-1:0]   cnt_q;

    logic [XW-1:0]   m_load_c;
    logic [XW-1:0]   q_load_c;
    logic [AW-1:0]   m_ext_c;
    logic [AW-1:0]   m2_c;
    logic [AW-1:0]   a_sum_c;
    logic [AW-1:0]   a_shift_c;
    logic [XW-1:0]   q_shift_c;
    logic            last_c;

    booth_r4_enc u_enc (
        .triple ({q_q[1:0], qm1_q}),
        .op_c   (op_c)
    );

    // Control: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        last_c     = (cnt_q == CW'(1));
        case (state)
            IDLE:    if (start) state_next = LOAD;
            LOAD:    state_next = RUN;
            RUN:     if (last_c) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they align with it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_next == LOAD) || (state_next == RUN);
            done <= (state_next == DONE);
        end
    end

    // Operand extension to WIDTH+2 so unsigned values keep a zero sign bit
    always_comb begin
        m_load_c = signed_mode ? {{2{multiplicand[WIDTH-1]}}, multiplicand}
                               : {2'b00, multiplicand};
        q_load_c = signed_mode ? {{2{multiplier[WIDTH-1]}}, multiplier}
                               : {2'b00, multiplier};
    end

    // One Booth digit: add the selected multiple, then arithmetic shift by 2
    always_comb begin
        m_ext_c = {m_q[XW-1], m_q};
        m2_c    = {m_q, 1'b0};
        a_sum_c = a_q;
        case (op_c)
            ADD_M:   a_sum_c = a_q + m_ext_c;
            ADD_2M:  a_sum_c = a_q + m2_c;
            SUB_M:   a_sum_c = a_q - m_ext_c;
            SUB_2M:  a_sum_c = a_q - m2_c;
            default: a_sum_c = a_q;
        endcase
        a_shift_c = {{2{a_sum_c[AW-1]}}, a_sum_c[AW-1:2]};
        q_shift_c = {a_sum_c[1:0], q_q[XW-1:2]};
    end

    // Operands are captured on the accepting edge, so later input changes
    // cannot disturb an operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q     <= '0;
            q_q     <= '0;
            qm1_q   <= 1'b0;
            a_q     <= '0;
            cnt_q   <= '0;
            product <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        m_q   <= m_load_c;
                        q_q   <= q_load_c;
                        qm1_q <= 1'b0;
                        a_q   <= '0;
                        cnt_q <= CW'(NDIG);
                    end
                end
                RUN: begin
                    a_q   <= a_shift_c;
                    q_q   <= q_shift_c;
                    qm1_q <= q_q[1];
                    cnt_q <= cnt_q - CW'(1);
                    if (last_c) begin
                        product <= {a_shift_c[WIDTH-3:0], q_shift_c};
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_r4_mult.sv
// Bench for booth_r4_mult at WIDTH=8: directed vectors plus a back-to-back
// sweep, checked every cycle against an arithmetic reference model.
module tb_booth_r4_mult;

    localparam int unsigned W    = 8;
    localparam int unsigned LAT  = 7;
    localparam int unsigned NRND = 10000;

    logic           clk;
    logic           rst;
    logic           start;
    logic           signed_mode;
    logic [W-1:0]   multiplicand;
    logic [W-1:0]   multiplier;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;

    int             checks   = 0;
    int             failures = 0;
    logic           chk_en   = 1'b0;

    logic           pin_en  = 1'b0;
    logic [2*W-1:0] pin_val = '0;

    int             pos         = 0;
    logic [2*W-1:0] cap_prod    = '0;
    logic [2*W-1:0] exp_prod    = '0;
    logic           cap_pin_en  = 1'b0;
    logic [2*W-1:0] cap_pin_val = '0;

    logic [W-1:0]   corners [4] = '{8'h00, 8'h7F, 8'h80, 8'hFF};

    booth_r4_mult #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .signed_mode  (signed_mode),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .product      (product)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [2*W-1:0] ref_mul(input logic sm, input logic [W-1:0] m,
                                               input logic [W-1:0] q);
        longint a;
        longint b;
        a = sm ? longint'($signed(m)) : longint'(m);
        b = sm ? longint'($signed(q)) : longint'(q);
        return (2*W)'(a * b);
    endfunction

    // Reference model: accept in idle, done LAT cycles later, result from plain arithmetic
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pos      <= 0;
            exp_prod <= '0;
        end else if (pos == 0) begin
            if (start) begin
                pos         <= 1;
                cap_prod    <= ref_mul(signed_mode, multiplicand, multiplier);
                cap_pin_en  <= pin_en;
                cap_pin_val <= pin_val;
            end
        end else if (pos == LAT) begin
            pos <= 0;
        end else begin
            pos <= pos + 1;
            if (pos == LAT - 1) exp_prod <= cap_prod;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%h expected=%h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", 32'(busy), 32'(pos >= 1 && pos <= LAT - 1));
            chk("done", 32'(done), 32'(pos == LAT));
            if (pos == 0 || pos == LAT) chk("product", 32'(product), 32'(exp_prod));
            if (pos == LAT && cap_pin_en) chk("pinned_product", 32'(product), 32'(cap_pin_val));
        end
    end

    task automatic do_op(input logic sm, input logic [W-1:0] m, input logic [W-1:0] q,
                         input logic pe, input logic [2*W-1:0] pv);
        signed_mode  = sm;
        multiplicand = m;
        multiplier   = q;
        pin_en       = pe;
        pin_val      = pv;
        start        = 1'b1;
        @(posedge clk);
        #1;
        start        = 1'b0;
        pin_en       = 1'b0;
        multiplicand = ~m;
        multiplier   = ~q;
        signed_mode  = ~sm;
        repeat (8) @(posedge clk);
        #1;
    endtask

    initial begin
        rst          = 1'b0;
        start        = 1'b0;
        signed_mode  = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        #1;
        rst    = 1'b1;
        chk_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        do_op(1'b1, 8'h80, 8'h80, 1'b1, 16'h4000);
        do_op(1'b0, 8'hFF, 8'hFF, 1'b1, 16'hFE01);
        do_op(1'b1, 8'hFF, 8'hFF, 1'b1, 16'h0001);
        do_op(1'b0, 8'h80, 8'h02, 1'b1, 16'h0100);
        do_op(1'b1, 8'h80, 8'h02, 1'b1, 16'hFF00);
        do_op(1'b1, 8'h7F, 8'h80, 1'b1, 16'hC080);
        do_op(1'b0, 8'h7F, 8'h80, 1'b1, 16'h3F80);
        do_op(1'b0, 8'h00, 8'hFF, 1'b1, 16'h0000);

        // start held through the operation with a new multiplicand must be ignored
        signed_mode  = 1'b1;
        multiplicand = 8'h07;
        multiplier   = 8'hFD;
        pin_en       = 1'b1;
        pin_val      = 16'hFFEB;
        start        = 1'b1;
        @(posedge clk);
        #1;
        multiplicand = 8'h00;
        pin_en       = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // reset during the third RUN cycle abandons the operation
        signed_mode  = 1'b0;
        multiplicand = 8'h55;
        multiplier   = 8'h33;
        start        = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        do_op(1'b0, 8'h03, 8'h05, 1'b1, 16'h000F);

        // back-to-back with start held high; operands change while in flight
        signed_mode  = 1'b0;
        multiplicand = 8'h0C;
        multiplier   = 8'h0B;
        pin_en       = 1'b1;
        pin_val      = 16'h0084;
        start        = 1'b1;
        for (int i = 0; i < NRND; i++) begin
            @(posedge clk);
            #1;
            if (i == NRND - 1) begin
                start  = 1'b0;
                pin_en = 1'b0;
            end else if (i == 0) begin
                signed_mode  = 1'b1;
                multiplicand = 8'hF6;
                multiplier   = 8'h0C;
                pin_val      = 16'hFF88;
            end else begin
                pin_en       = 1'b0;
                signed_mode  = 1'($urandom_range(0, 1));
                multiplicand = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)]
                                                           : W'($urandom);
                multiplier   = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)]
                                                           : W'($urandom);
            end
            repeat (7) @(posedge clk);
        end
        repeat (12) @(posedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
